// File: rtl/jtag_ir_controller_if.sv
// rtl/jtag_ir_controller_if.sv - TAP-side control and serial data bundle for the instruction register
//
// Purpose: carries the TAP controller's IR strobes, serial data in and out, and the status bits
//          that are captured into the instruction shift register.
// Signals: capture_ir, shift_ir, update_ir, tdi, ir_status[IR_WIDTH-3:0] (TAP -> IR),
//          tdo (IR -> TAP).
// Modports: master = TAP state machine side, slave = instruction register side.

interface jtag_ir_controller_if #(
  parameter int IR_WIDTH = 4
);
  logic                capture_ir;
  logic                shift_ir;
  logic                update_ir;
  logic                tdi;
  logic [IR_WIDTH-3:0] ir_status;
  logic                tdo;

  modport master (
    output capture_ir,
    output shift_ir,
    output update_ir,
    output tdi,
    output ir_status,
    input  tdo
  );

  modport slave (
    input  capture_ir,
    input  shift_ir,
    input  update_ir,
    input  tdi,
    input  ir_status,
    output tdo
  );
endinterface

// File: rtl/jtag_ir_controller.sv
// rtl/jtag_ir_controller.sv - JTAG instruction register with shadow latch and one-hot scan-mode decode
//
// Purpose: IR_WIDTH-bit instruction shift register (capture/shift) feeding a shadow register
//          (update); the shadow value is decoded into exactly one scan-mode enable.
//          Unknown opcodes fall back to BYPASS and raise illegal_op.
// Ports:   clk, rst (synchronous, active-high test-logic-reset)
//          tap              - TAP-side strobes, tdi/tdo and capture status (slave modport)
//          ir_active        - current (shadow) instruction
//          bypass_en, boundary_scan_en, sample_en, idcode_en, internal_scan_en - one-hot mode select
//          illegal_op       - ir_active matches no defined opcode

module jtag_ir_controller #(
  parameter int IR_WIDTH   = 4,
  parameter int OP_EXTEST  = 0,
  parameter int OP_SAMPLE  = 1,
  parameter int OP_IDCODE  = 2,
  parameter int OP_INTSCAN = 3,
  parameter int HAS_IDCODE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  jtag_ir_controller_if.slave   tap,
  output logic [IR_WIDTH-1:0]   ir_active,
  output logic                  bypass_en,
  output logic                  boundary_scan_en,
  output logic                  sample_en,
  output logic                  idcode_en,
  output logic                  internal_scan_en,
  output logic                  illegal_op
);

  localparam logic [IR_WIDTH-1:0] EXTEST_OP  = IR_WIDTH'(OP_EXTEST);
  localparam logic [IR_WIDTH-1:0] SAMPLE_OP  = IR_WIDTH'(OP_SAMPLE);
  localparam logic [IR_WIDTH-1:0] IDCODE_OP  = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] INTSCAN_OP = IR_WIDTH'(OP_INTSCAN);
  localparam logic [IR_WIDTH-1:0] BYPASS_OP  = {IR_WIDTH{1'b1}};
  localparam logic                IDCODE_ON  = (HAS_IDCODE != 0);
  localparam logic [IR_WIDTH-1:0] RESET_IR   = IDCODE_ON ? IDCODE_OP : BYPASS_OP;
  // Reset value matches a capture with all-zero status: pattern 01 in the LSBs.
  localparam logic [IR_WIDTH-1:0] RESET_SR   = IR_WIDTH'(1);

  logic [IR_WIDTH-1:0] shift_reg;

  // Capture wins over shift; the 01 pattern lets a board test detect a stuck chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= RESET_SR;
    end else if (tap.capture_ir) begin
      shift_reg <= {tap.ir_status, 2'b01};
    end else if (tap.shift_ir) begin
      shift_reg <= {tap.tdi, shift_reg[IR_WIDTH-1:1]};
    end
  end

  // Update samples the pre-edge shift_reg, so it may coincide with capture or shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_active <= RESET_IR;
    end else if (tap.update_ir) begin
      ir_active <= shift_reg;
    end
  end

  assign tap.tdo = shift_reg[0];

  // Decode from the shadow register only; the if-chain guarantees one-hot enables.
  always_comb begin
    bypass_en        = 1'b0;
    boundary_scan_en = 1'b0;
    sample_en        = 1'b0;
    idcode_en        = 1'b0;
    internal_scan_en = 1'b0;
    illegal_op       = 1'b0;
    if (ir_active == EXTEST_OP) begin
      boundary_scan_en = 1'b1;
    end else if (ir_active == SAMPLE_OP) begin
      sample_en = 1'b1;
    end else if (IDCODE_ON && (ir_active == IDCODE_OP)) begin
      idcode_en = 1'b1;
    end else if (ir_active == INTSCAN_OP) begin
      internal_scan_en = 1'b1;
    end else begin
      bypass_en  = 1'b1;
      illegal_op = (ir_active != BYPASS_OP);
    end
  end

endmodule

// File: tb/tb_jtag_ir_controller.sv
// tb/tb_jtag_ir_controller.sv - scoreboard bench for jtag_ir_controller (HAS_IDCODE=1 and 0)

module tb_jtag_ir_controller;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtag_ir_controller_if #(.IR_WIDTH(W)) bus_a ();
  jtag_ir_controller_if #(.IR_WIDTH(W)) bus_b ();

  logic [W-1:0] ir_a, ir_b;
  logic byp_a, bsc_a, smp_a, idc_a, int_a, ill_a;
  logic byp_b, bsc_b, smp_b, idc_b, int_b, ill_b;

  jtag_ir_controller #(.IR_WIDTH(W), .HAS_IDCODE(1)) dut_a (
    .clk(clk), .rst(rst), .tap(bus_a.slave), .ir_active(ir_a),
    .bypass_en(byp_a), .boundary_scan_en(bsc_a), .sample_en(smp_a),
    .idcode_en(idc_a), .internal_scan_en(int_a), .illegal_op(ill_a)
  );

  jtag_ir_controller #(.IR_WIDTH(W), .HAS_IDCODE(0)) dut_b (
    .clk(clk), .rst(rst), .tap(bus_b.slave), .ir_active(ir_b),
    .bypass_en(byp_b), .boundary_scan_en(bsc_b), .sample_en(smp_b),
    .idcode_en(idc_b), .internal_scan_en(int_b), .illegal_op(ill_b)
  );

  // Enables packed as {bypass, extest, sample, idcode, intscan}.
  typedef struct {
    logic         tdo;
    logic [W-1:0] ir_a;
    logic [W-1:0] ir_b;
    logic [4:0]   en_a;
    logic [4:0]   en_b;
    logic         ill_a;
    logic         ill_b;
  } exp_t;

  exp_t exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  // Reference model state, kept as plain integers.
  int m_sr, m_ir_a, m_ir_b;

  function automatic void decode(input int ir, input bit has_id,
                                 output logic [4:0] en, output logic ill);
    ill = 1'b0;
    case (ir)
      0:       en = 5'b01000;
      1:       en = 5'b00100;
      2:       if (has_id) en = 5'b00010; else begin en = 5'b10000; ill = 1'b1; end
      3:       en = 5'b00001;
      15:      en = 5'b10000;
      default: begin en = 5'b10000; ill = 1'b1; end
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: outputs depend only on registers, so the negedge sample is stable.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("tdo_a", int'(bus_a.tdo), int'(e.tdo));
      check("tdo_b", int'(bus_b.tdo), int'(e.tdo));
      check("ir_active_a", int'(ir_a), int'(e.ir_a));
      check("ir_active_b", int'(ir_b), int'(e.ir_b));
      check("enables_a", int'({byp_a, bsc_a, smp_a, idc_a, int_a}), int'(e.en_a));
      check("enables_b", int'({byp_b, bsc_b, smp_b, idc_b, int_b}), int'(e.en_b));
      check("illegal_a", int'(ill_a), int'(e.ill_a));
      check("illegal_b", int'(ill_b), int'(e.ill_b));
    end
  end

  // One clock edge with the given controls; the model advances and its prediction is queued.
  task automatic step(input bit r, input bit c, input bit s, input bit u,
                      input bit t, input int status);
    exp_t e;
    int   pre_sr;
    rst = r;
    bus_a.capture_ir = c; bus_a.shift_ir = s; bus_a.update_ir = u;
    bus_a.tdi = t; bus_a.ir_status = 2'(status);
    bus_b.capture_ir = c; bus_b.shift_ir = s; bus_b.update_ir = u;
    bus_b.tdi = t; bus_b.ir_status = 2'(status);
    @(posedge clk);
    #1;
    pre_sr = m_sr;
    if (r) begin
      m_sr = 1; m_ir_a = 2; m_ir_b = 15;
    end else begin
      if (c)      m_sr = ((status % 4) * 4) + 1;
      else if (s) m_sr = (m_sr / 2) + (int'(t) * (1 << (W - 1)));
      if (u) begin m_ir_a = pre_sr; m_ir_b = pre_sr; end
    end
    e.tdo  = logic'(m_sr % 2);
    e.ir_a = W'(m_ir_a);
    e.ir_b = W'(m_ir_b);
    decode(m_ir_a, 1'b1, e.en_a, e.ill_a);
    decode(m_ir_b, 1'b0, e.en_b, e.ill_b);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic shift_in(input int op);
    for (int i = 0; i < W; i++) step(0, 0, 1, 0, ((op >> i) & 1) != 0, 0);
  endtask

  task automatic load(input int op);
    step(0, 1, 0, 0, 0, $urandom_range(0, 3));
    shift_in(op);
    step(0, 0, 0, 1, 0, 0);
    idle(1);
  endtask

  initial begin
    m_sr = 1; m_ir_a = 2; m_ir_b = 15;
    rst = 1'b1;
    bus_a.capture_ir = 0; bus_a.shift_ir = 0; bus_a.update_ir = 0; bus_a.tdi = 0; bus_a.ir_status = 0;
    bus_b.capture_ir = 0; bus_b.shift_ir = 0; bus_b.update_ir = 0; bus_b.tdi = 0; bus_b.ir_status = 0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(2);

    // Capture with status 10, shift four ones: tdo 1,0,0,1, then update to BYPASS.
    step(0, 1, 0, 0, 0, 2);
    for (int i = 0; i < W; i++) step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(1);

    load(3);
    load(0);
    load(1);
    load(2);
    load(5);

    // Shift without update leaves the instruction alone; contents hold while idle.
    step(0, 1, 0, 0, 0, 1);
    shift_in(4'b0011);
    idle(3);
    // Update and capture on the same edge.
    step(0, 1, 0, 1, 0, 2);
    idle(1);

    // Reset in the middle of a shift, together with update.
    step(0, 1, 0, 0, 0, 3);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 1, 0);
    idle(2);

    // Randomised traffic: mix of full loads and raw control cycles.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        int pick;
        pick = $urandom_range(0, 5);
        load(pick < 4 ? pick : (pick == 4 ? 15 : int'($urandom_range(0, 15))));
      end else begin
        for (int j = 0; j < 4; j++)
          step($urandom_range(0, 40) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 3));
      end
    end
    idle(2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
